addr_calc_arb: RTL and testbench

- Parametrised successor to the three-channel FFT/FIR/IIR address calculator.
- Serves NUM_CH processing channels. Each channel has an independent read pointer and write pointer.
- One address per cycle goes onto a shared address bus, chosen by round-robin arbitration across channels.
- A registered addr_valid replaces tri-stating the bus. A circular (ring-buffer) mode is added.

---
 rtl/addr_calc_arb.sv | 166 ++++++++++++++++
 tb/tb_addr_calc_arb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/addr_calc_arb.sv
// Multi-channel read/write address generator sharing one registered address bus.
// Channels are picked round-robin; a read/write toggle alternates inside a channel.
module addr_calc_arb #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] offset,
    input  logic [CNT_W-1:0]  filesize,
    input  logic              circular,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] ch_read_pause,
    input  logic [NUM_CH-1:0] ch_write_pause,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic [CH_W-1:0]   addr_ch,
    output logic              addr_is_write,
    output logic [NUM_CH-1:0] read_done,
    output logic [NUM_CH-1:0] write_done
);

    logic [CNT_W-1:0]  rd_ptr_q [NUM_CH];
    logic [CNT_W-1:0]  rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0]  wr_ptr_q [NUM_CH];
    logic [CNT_W-1:0]  wr_ptr_d [NUM_CH];
    logic [NUM_CH-1:0] read_done_q, read_done_d;
    logic [NUM_CH-1:0] write_done_q, write_done_d;
    logic [NUM_CH-1:0] tog_q, tog_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d;
    logic [CH_W-1:0]   addr_ch_q, addr_ch_d;
    logic              addr_is_write_q, addr_is_write_d;

    logic [NUM_CH-1:0] rd_req, wr_req, req;
    logic              fs_nz;
    logic [CNT_W-1:0]  fs_last;
    logic [ADDR_W-1:0] fs_a;

    assign fs_nz   = (filesize != '0);
    assign fs_last = filesize - CNT_W'(1);
    assign fs_a    = ADDR_W'(filesize);

    // In circular mode done is only a wrap pulse, so it must not stall the stream.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_req
        assign rd_req[gi] = ch_enable[gi] & ~ch_read_pause[gi]
                          & ~(read_done_q[gi] & ~circular) & fs_nz;
        assign wr_req[gi] = ch_enable[gi] & ~ch_write_pause[gi]
                          & ~(write_done_q[gi] & ~circular) & fs_nz;
        assign req[gi]    = rd_req[gi] | wr_req[gi];
    end

    int                g_sel;
    logic              found;
    logic              do_write;
    logic [ADDR_W-1:0] base;

    always_comb begin
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        read_done_d     = read_done_q;
        write_done_d    = write_done_q;
        tog_d           = tog_q;
        rr_d            = rr_q;
        addr_d          = addr_q;
        addr_valid_d    = 1'b0;
        addr_ch_d       = addr_ch_q;
        addr_is_write_d = addr_is_write_q;
        g_sel           = 0;
        found           = 1'b0;
        do_write        = 1'b0;
        base            = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            if (!ch_enable[c]) begin
                rd_ptr_d[c]     = '0;
                wr_ptr_d[c]     = '0;
                read_done_d[c]  = 1'b0;
                write_done_d[c] = 1'b0;
                tog_d[c]        = 1'b0;
            end else if (circular) begin
                read_done_d[c]  = 1'b0;
                write_done_d[c] = 1'b0;
            end
        end

        // Lowest requester overall, then overridden by the lowest at or above rr_q.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (req[c]) begin
                g_sel = c;
                found = 1'b1;
            end
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (req[c] && c >= int'(rr_q)) g_sel = c;
        end

        for (int c = 0; c < NUM_CH; c++) begin
            if (found && c == g_sel) begin
                do_write = wr_req[c] & (~rd_req[c] | tog_q[c]);
                if (rd_req[c] && wr_req[c]) tog_d[c] = ~tog_q[c];
                base = offset + ADDR_W'(c) * (fs_a + fs_a);
                rr_d = CH_W'((c + 1) % NUM_CH);
                addr_valid_d    = 1'b1;
                addr_ch_d       = CH_W'(c);
                addr_is_write_d = do_write;
                if (do_write) begin
                    addr_d = base + fs_a + ADDR_W'(wr_ptr_q[c]);
                    if (wr_ptr_q[c] == fs_last) begin
                        write_done_d[c] = 1'b1;
                        if (circular) wr_ptr_d[c] = '0;
                    end else begin
                        wr_ptr_d[c] = wr_ptr_q[c] + CNT_W'(1);
                    end
                end else begin
                    addr_d = base + ADDR_W'(rd_ptr_q[c]);
                    if (rd_ptr_q[c] == fs_last) begin
                        read_done_d[c] = 1'b1;
                        if (circular) rd_ptr_d[c] = '0;
                    end else begin
                        rd_ptr_d[c] = rd_ptr_q[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
            end
            read_done_q     <= '0;
            write_done_q    <= '0;
            tog_q           <= '0;
            rr_q            <= '0;
            addr_q          <= '0;
            addr_valid_q    <= 1'b0;
            addr_ch_q       <= '0;
            addr_is_write_q <= 1'b0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            read_done_q     <= read_done_d;
            write_done_q    <= write_done_d;
            tog_q           <= tog_d;
            rr_q            <= rr_d;
            addr_q          <= addr_d;
            addr_valid_q    <= addr_valid_d;
            addr_ch_q       <= addr_ch_d;
            addr_is_write_q <= addr_is_write_d;
        end
    end

    assign addr          = addr_q;
    assign addr_valid    = addr_valid_q;
    assign addr_ch       = addr_ch_q;
    assign addr_is_write = addr_is_write_q;
    assign read_done     = read_done_q;
    assign write_done    = write_done_q;

endmodule

// File: tb/tb_addr_calc_arb.sv
// Directed bench for addr_calc_arb: one-shot, pause, multi-channel, alternation,
// circular wrap and mid-stream reset, with hand-computed expected addresses.
module tb_addr_calc_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] offset;
    logic [31:0] filesize;
    logic        circular;
    logic [2:0]  ch_enable, ch_read_pause, ch_write_pause;
    logic [31:0] addr;
    logic        addr_valid;
    logic [1:0]  addr_ch;
    logic        addr_is_write;
    logic [2:0]  read_done, write_done;

    int n_cmp = 0;
    int n_err = 0;

    addr_calc_arb #(.NUM_CH(3), .ADDR_W(32), .CNT_W(32), .CH_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .offset(offset), .filesize(filesize),
        .circular(circular), .ch_enable(ch_enable), .ch_read_pause(ch_read_pause),
        .ch_write_pause(ch_write_pause), .addr(addr), .addr_valid(addr_valid),
        .addr_ch(addr_ch), .addr_is_write(addr_is_write),
        .read_done(read_done), .write_done(write_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next issue (allowing up to max_wait idle cycles) and check it.
    task automatic expect_issue(input string tag, input logic [31:0] ea,
                                input logic [1:0] ech, input logic ew, input int max_wait);
        int w = 0;
        tick();
        while (addr_valid !== 1'b1 && w < max_wait) begin
            tick();
            w++;
        end
        $display("issue %s addr=%0d ch=%0d wr=%0d valid=%0b", tag, addr, addr_ch,
                 addr_is_write, addr_valid);
        check({tag, "_valid"}, 64'(addr_valid), 64'(1'b1));
        check({tag, "_addr"}, 64'(addr), 64'(ea));
        check({tag, "_ch"}, 64'(addr_ch), 64'(ech));
        check({tag, "_wr"}, 64'(addr_is_write), 64'(ew));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; offset = 32'd10; filesize = 32'd100; circular = 1'b0;
        ch_enable = 3'b111; ch_read_pause = 3'b000; ch_write_pause = 3'b000;

        // 1: reset clears everything, first address one cycle after release
        tick();
        tick();
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_valid", 64'(addr_valid), 64'd0);
        check("rst_ch", 64'(addr_ch), 64'd0);
        check("rst_wr", 64'(addr_is_write), 64'd0);
        check("rst_rdone", 64'(read_done), 64'd0);
        check("rst_wdone", 64'(write_done), 64'd0);
        rst_n = 1'b1;
        expect_issue("t1_first", 32'd10, 2'd0, 1'b0, 0);
        ch_enable = 3'b000;
        do_reset();

        // 2: ch0 read-only with a 25-cycle pause after 50 words
        ch_enable = 3'b001; ch_write_pause = 3'b001;
        for (int i = 0; i < 50; i++) begin
            expect_issue("t2_rd", 32'(10 + i), 2'd0, 1'b0, 0);
            check("t2_done_lo", 64'(read_done), 64'd0);
        end
        ch_read_pause = 3'b001;
        for (int i = 0; i < 25; i++) begin
            tick();
            check("t2_pause_valid", 64'(addr_valid), 64'd0);
        end
        ch_read_pause = 3'b000;
        for (int i = 50; i < 100; i++) begin
            expect_issue("t2_rd", 32'(10 + i), 2'd0, 1'b0, 0);
            check("t2_done", 64'(read_done), (i == 99) ? 64'd1 : 64'd0);
        end
        tick();
        check("t2_end_valid", 64'(addr_valid), 64'd0);
        check("t2_end_addr", 64'(addr), 64'd109);
        check("t2_sticky", 64'(read_done), 64'd1);

        // 3: disable clears done, then ch0 write-only
        ch_enable = 3'b000;
        tick();
        check("t3_dis_rdone", 64'(read_done), 64'd0);
        ch_enable = 3'b001; ch_read_pause = 3'b001; ch_write_pause = 3'b000;
        for (int i = 0; i < 100; i++) begin
            expect_issue("t3_wr", 32'(110 + i), 2'd0, 1'b1, 0);
            check("t3_done", 64'(write_done), (i == 99) ? 64'd1 : 64'd0);
        end
        ch_enable = 3'b000;
        tick();
        check("t3_dis_wdone", 64'(write_done), 64'd0);
        check("t3_dis_valid", 64'(addr_valid), 64'd0);

        // 4: three channels reading, round-robin
        do_reset();
        ch_enable = 3'b111; ch_read_pause = 3'b000; ch_write_pause = 3'b111;
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 3; j++) begin
                expect_issue("t4_rd", 32'(10 + 200 * j + i), 2'(j), 1'b0, 0);
                check("t4_done", 64'(read_done),
                      (i == 99) ? 64'((1 << (j + 1)) - 1) : 64'd0);
            end
        end
        tick();
        check("t4_end_valid", 64'(addr_valid), 64'd0);
        check("t4_end_done", 64'(read_done), 64'd7);

        // 5: ch0 read and write alternate, read first
        ch_enable = 3'b000;
        tick();
        ch_enable = 3'b001; ch_read_pause = 3'b000; ch_write_pause = 3'b000;
        for (int i = 0; i < 10; i++) begin
            expect_issue("t5_rd", 32'(10 + i), 2'd0, 1'b0, 0);
            expect_issue("t5_wr", 32'(110 + i), 2'd0, 1'b1, 0);
        end

        // 6: circular ring of 4 with done pulse on each wrap, then mid-stream reset
        ch_enable = 3'b000;
        tick();
        circular = 1'b1; filesize = 32'd4;
        ch_enable = 3'b001; ch_write_pause = 3'b001;
        for (int k = 0; k < 10; k++) begin
            expect_issue("t6_rd", 32'(10 + (k % 4)), 2'd0, 1'b0, 1);
            check("t6_pulse", 64'(read_done), (k % 4 == 3) ? 64'd1 : 64'd0);
        end
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", 64'(addr_valid), 64'd0);
        check("t6_rst_addr", 64'(addr), 64'd0);
        rst_n = 1'b1;
        expect_issue("t6_restart", 32'd10, 2'd0, 1'b0, 0);

        // filesize = 0 raises no requests and no done
        ch_enable = 3'b000;
        tick();
        circular = 1'b0; filesize = 32'd0;
        ch_enable = 3'b111; ch_write_pause = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fs0_valid", 64'(addr_valid), 64'd0);
            check("fs0_done", 64'({read_done, write_done}), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
